// File: rtl/apb_pkg.sv
// Shared types for the APB register-file slave: FSM state encoding and wait-counter width.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/apb_byte_regfile.sv
// DEPTH x DATA_W flop array with async clear, one byte-strobed write port and one read port.
// Write lands on the clock edge; read is combinational; no backpressure.
module apb_byte_regfile #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata
);
    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 leaf slave fronting a byte-strobed register file, PSLVERR on misaligned/out-of-range addresses.
// Access phase lasts WAIT_CYCLES+1 cycles; pready/prdata/pslverr come straight from flops.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                psel,
    input  logic                penable,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic                pwrite,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic                pready,
    output logic [DATA_W-1:0]   prdata,
    output logic                pslverr
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFS_W  = $clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pready_d, pslverr_d;
    logic [DATA_W-1:0] prdata_d;
    logic              wr_en;

    logic [ADDR_W-1:0] idx_full;
    logic [IDX_W-1:0]  idx;
    logic              err;
    logic [DATA_W-1:0] rd_dat;
    logic [DATA_W-1:0] resp;
    logic              setup;

    // Index is widened by one bit so DEPTH == 2**ADDR_W still compares correctly.
    assign idx_full = paddr >> OFS_W;
    assign idx      = idx_full[IDX_W-1:0];
    assign err      = ((paddr & ADDR_W'(STRB_W - 1)) != '0) ||
                      ({1'b0, idx_full} >= (ADDR_W+1)'(DEPTH));
    assign resp     = (!pwrite && !err) ? rd_dat : '0;
    assign setup    = psel && !penable;

    apb_byte_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_regs (
        .clk    (clk),
        .reset  (reset),
        .we     (wr_en),
        .waddr  (idx),
        .wstrb  (pstrb),
        .wdata  (pwdata),
        .raddr  (idx),
        .rdata  (rd_dat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (setup) state_d = ACCESS;
            ACCESS:  if (!psel || (penable && pready)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        pready_d  = pready;
        prdata_d  = prdata;
        pslverr_d = pslverr;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    cnt_d = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        pready_d  = 1'b1;
                        prdata_d  = resp;
                        pslverr_d = err;
                    end else begin
                        pready_d  = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (!psel) begin
                    // Abort: master walked away, drop the transfer without a write.
                    cnt_d     = '0;
                    pready_d  = 1'b0;
                    prdata_d  = '0;
                    pslverr_d = 1'b0;
                end else if (penable && pready) begin
                    wr_en     = pwrite && !err;
                    pready_d  = 1'b0;
                    prdata_d  = '0;
                    pslverr_d = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        pready_d  = 1'b1;
                        prdata_d  = resp;
                        pslverr_d = err;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pready  <= pready_d;
            prdata  <= prdata_d;
            pslverr <= pslverr_d;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: one instance with no wait states, one with three.
module tb_apb_slave_regfile;
    logic        clk = 1'b0;
    logic        reset, psel, penable, pwrite, use3;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        psel0, psel3, pready0, pready3, pslverr0, pslverr3;
    logic [31:0] prdata0, prdata3;
    logic        pready_m, pslverr_m;
    logic [31:0] prdata_m;

    always #5 clk = ~clk;

    assign psel0     = psel & ~use3;
    assign psel3     = psel & use3;
    assign pready_m  = use3 ? pready3  : pready0;
    assign pslverr_m = use3 ? pslverr3 : pslverr0;
    assign prdata_m  = use3 ? prdata3  : prdata0;

    apb_slave_regfile #(.ADDR_W(10), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .psel(psel0), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready0), .prdata(prdata0), .pslverr(pslverr0));

    apb_slave_regfile #(.ADDR_W(10), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .psel(psel3), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready3), .prdata(prdata3), .pslverr(pslverr3));

    typedef struct {
        bit          w3;
        bit          wr;
        logic [9:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] rd;
        bit          err;
        int          waits;
    } vec_t;

    vec_t        tbl [16];
    logic [31:0] mdl [16];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    // Leaves the bus in the access phase with pready seen high; the next
    // call's first edge is the completion edge, so calls chain back-to-back.
    task automatic xfer(input bit w3, input bit wr, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic err,
                        output int waits);
        @(posedge clk); #1;
        use3 = w3; psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (!pready_m && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        rd  = prdata_m;
        err = pslverr_m;
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("idle_pready", {31'd0, pready_m}, 32'd0);
        chk("idle_prdata", prdata_m, 32'd0);
    endtask

    task automatic readback(input string tag);
        logic [31:0] rd;
        logic        err;
        int          w;
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, 1'b0, 10'(i * 4), 32'd0, 4'h0, rd, err, w);
            chk($sformatf("%s_rd[%0d]", tag, i), rd, mdl[i]);
            chk($sformatf("%s_err[%0d]", tag, i), {31'd0, err}, 32'd0);
        end
        bus_idle();
    endtask

    initial begin
        logic [31:0] rd, d;
        logic        err;
        logic [3:0]  s;
        int          w;

        tbl[0]  = '{1'b0, 1'b1, 10'h004, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 0};
        tbl[1]  = '{1'b0, 1'b0, 10'h004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b0, 10'h008, 32'h0,        4'h0, 32'h0,        1'b0, 3};
        tbl[3]  = '{1'b0, 1'b1, 10'h00C, 32'h11223344, 4'hF, 32'h0,        1'b0, 0};
        tbl[4]  = '{1'b0, 1'b1, 10'h00C, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 0};
        tbl[5]  = '{1'b0, 1'b0, 10'h00C, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 0};
        tbl[6]  = '{1'b0, 1'b1, 10'h040, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 0};
        tbl[7]  = '{1'b0, 1'b0, 10'h002, 32'h0,        4'h0, 32'h0,        1'b1, 0};
        tbl[8]  = '{1'b0, 1'b1, 10'h008, 32'h12345678, 4'h0, 32'h0,        1'b0, 0};
        tbl[9]  = '{1'b0, 1'b0, 10'h008, 32'h0,        4'h0, 32'h0,        1'b0, 0};
        tbl[10] = '{1'b0, 1'b1, 10'h03C, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 0};
        tbl[11] = '{1'b0, 1'b0, 10'h03C, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 0};
        tbl[12] = '{1'b1, 1'b1, 10'h010, 32'h55AA55AA, 4'hF, 32'h0,        1'b0, 3};
        tbl[13] = '{1'b1, 1'b0, 10'h010, 32'h0,        4'h0, 32'h55AA55AA, 1'b0, 3};
        tbl[14] = '{1'b1, 1'b0, 10'h041, 32'h0,        4'h0, 32'h0,        1'b1, 3};
        tbl[15] = '{1'b1, 1'b0, 10'h3FC, 32'h0,        4'h0, 32'h0,        1'b1, 3};
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;

        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; use3 = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        #1;
        chk("rst_pready0",  {31'd0, pready0},  32'd0);
        chk("rst_pslverr0", {31'd0, pslverr0}, 32'd0);
        chk("rst_prdata0",  prdata0, 32'd0);
        chk("rst_pready3",  {31'd0, pready3},  32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            xfer(tbl[i].w3, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, rd, err, w);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, tbl[i].err});
            chk($sformatf("vec%0d_waits", i), w, tbl[i].waits);
            if (tbl[i].wr && !tbl[i].w3 && !tbl[i].err)
                mdl[tbl[i].a[5:2]] = merge(mdl[tbl[i].a[5:2]], tbl[i].d, tbl[i].s);
        end
        bus_idle();
        readback("post_err");

        // Abort a WAIT=3 write by dropping psel mid access phase.
        @(posedge clk); #1;
        use3 = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 10'h014; pwdata = 32'h0BADF00D; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("abort_pready_acc", {31'd0, pready3}, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_pready[%0d]", i), {31'd0, pready3}, 32'd0);
        end
        xfer(1'b1, 1'b0, 10'h014, 32'd0, 4'h0, rd, err, w);
        chk("abort_noupdate", rd, 32'h0);
        chk("abort_waits", w, 3);

        // Reset lands while the WAIT=3 slave is presenting read data.
        xfer(1'b1, 1'b0, 10'h010, 32'd0, 4'h0, rd, err, w);
        chk("prereset_rdata", rd, 32'h55AA55AA);
        #1 reset = 1'b1;
        #1;
        chk("midrst_pready",  {31'd0, pready3},  32'd0);
        chk("midrst_prdata",  prdata3, 32'd0);
        chk("midrst_pslverr", {31'd0, pslverr3}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        xfer(1'b1, 1'b0, 10'h010, 32'd0, 4'h0, rd, err, w);
        chk("postrst_w3_rd", rd, 32'h0);
        xfer(1'b0, 1'b0, 10'h004, 32'd0, 4'h0, rd, err, w);
        chk("postrst_w0_rd", rd, 32'h0);
        bus_idle();

        // Stray penable without psel must not start a transfer.
        use3 = 1'b0; penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stray_pready[%0d]", i), {31'd0, pready0}, 32'd0);
        end
        penable = 1'b0;

        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            xfer(1'b0, 1'b1, 10'(i * 4), d, s, rd, err, w);
            chk($sformatf("b2b_wr_err[%0d]", i), {31'd0, err}, 32'd0);
            chk($sformatf("b2b_wr_waits[%0d]", i), w, 0);
            mdl[i] = merge(mdl[i], d, s);
            xfer(1'b0, 1'b0, 10'(i * 4), 32'd0, 4'h0, rd, err, w);
            chk($sformatf("b2b_rd[%0d]", i), rd, mdl[i]);
        end
        bus_idle();
        readback("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
